// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter: sequences the single-ported data memory between LSQ loads and retired-store drain.
// Optional macro DMEM_ARB_STARVE_EN bounds consecutive store grants while a load waits.
`default_nettype none

module dmem_port_arbiter #(
  parameter int MEM_LAT = 2
`ifdef DMEM_ARB_STARVE_EN
  , parameter int STARVE_LIMIT = 4
`endif
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ld_req_valid,
  input  logic [31:0] ld_req_addr,
  input  logic [6:0]  ld_req_pd,
  input  logic [4:0]  ld_req_rob,
  output logic        ld_req_ready,
  input  logic        st_req_valid,
  input  logic [31:0] st_req_addr,
  input  logic [31:0] st_req_data,
  output logic        st_req_ready,
  input  logic [4:0]  rob_head,
  input  logic        mispredict,
  input  logic [4:0]  mispredict_tag,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        ld_resp_valid,
  output logic [6:0]  ld_resp_pd,
  output logic [4:0]  ld_resp_rob,
  output logic [31:0] ld_resp_data,
  output logic        st_done,
  output logic        busy
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_LD_WAIT = 2'd1;
  localparam logic [1:0] S_ST_ACK  = 2'd2;

  logic [1:0]  r_state;
  logic [2:0]  r_cnt;
  logic        r_squash;
  logic        r_resp_pend;
  logic [6:0]  r_ld_pd;
  logic [4:0]  r_ld_rob;
  logic [31:0] r_resp_data;
  logic [31:0] r_mem_addr;
  logic [31:0] r_mem_wdata;

  logic        w_idle;
  logic        w_ld_ok;
  logic        w_st_win;
  logic        w_st_grant;
  logic        w_ld_grant;
  logic [4:0]  w_age_ld;
  logic [4:0]  w_age_mp;
  logic        w_kill;
  logic [31:0] w_mem_addr;
  logic [31:0] w_mem_wdata;

  // Readys are gated by reset so every output reads 0 while reset is held.
  assign w_idle  = (r_state == S_IDLE) && reset;
  assign w_ld_ok = ld_req_valid && !mispredict;

`ifdef DMEM_ARB_STARVE_EN
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  logic [SW-1:0] r_starve_cnt;
  logic          w_starved;

  assign w_starved = (r_starve_cnt == SW'(STARVE_LIMIT));
  assign w_st_win  = st_req_valid && !(w_starved && w_ld_ok);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_starve_cnt <= '0;
    end else if (w_ld_grant || !ld_req_valid) begin
      r_starve_cnt <= '0;
    end else if (w_st_grant && !w_starved) begin
      r_starve_cnt <= r_starve_cnt + 1'b1;
    end
  end
`else
  assign w_st_win = st_req_valid;
`endif

  assign w_st_grant = w_idle && w_st_win;
  assign w_ld_grant = w_idle && !w_st_win && w_ld_ok;

  assign w_mem_addr  = w_st_grant ? st_req_addr :
                       w_ld_grant ? ld_req_addr : r_mem_addr;
  assign w_mem_wdata = w_st_grant ? st_req_data : r_mem_wdata;

  // Ages relative to the ROB head; a larger age is younger in program order.
  assign w_age_ld = r_ld_rob - rob_head;
  assign w_age_mp = mispredict_tag - rob_head;
  assign w_kill   = mispredict && (w_age_ld > w_age_mp);

  assign st_req_ready  = w_st_grant;
  assign ld_req_ready  = w_ld_grant;
  assign mem_en        = w_st_grant || w_ld_grant;
  assign mem_we        = w_st_grant;
  assign mem_addr      = w_mem_addr;
  assign mem_wdata     = w_mem_wdata;
  assign ld_resp_valid = r_resp_pend && !w_kill;
  assign ld_resp_pd    = r_ld_pd;
  assign ld_resp_rob   = r_ld_rob;
  assign ld_resp_data  = r_resp_data;
  assign st_done       = (r_state == S_ST_ACK);
  assign busy          = (r_state != S_IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_squash    <= 1'b0;
      r_resp_pend <= 1'b0;
      r_ld_pd     <= '0;
      r_ld_rob    <= '0;
      r_resp_data <= '0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      r_resp_pend <= 1'b0;
      r_mem_addr  <= w_mem_addr;
      r_mem_wdata <= w_mem_wdata;
      case (r_state)
        S_IDLE: begin
          if (w_st_grant) begin
            r_state <= S_ST_ACK;
          end else if (w_ld_grant) begin
            r_state  <= S_LD_WAIT;
            r_ld_pd  <= ld_req_pd;
            r_ld_rob <= ld_req_rob;
            r_cnt    <= 3'(MEM_LAT - 1);
            r_squash <= 1'b0;
          end
        end
        S_LD_WAIT: begin
          if (w_kill) begin
            r_squash <= 1'b1;
          end
          if (r_cnt == 3'd0) begin
            r_resp_data <= mem_rdata;
            r_resp_pend <= !(r_squash || w_kill);
            r_state     <= S_IDLE;
          end else begin
            r_cnt <= r_cnt - 3'd1;
          end
        end
        S_ST_ACK: r_state <= S_IDLE;
        default:  r_state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: doc/dmem_port_arbiter.md
Name: dmem_port_arbiter

Overview:
- Sequences the single-ported data memory and shares it between two requesters: LSQ load issue and retired-store drain.
- Tracks the one outstanding access, waits out fixed memory latency, returns load data tagged with pd/rob, and signals store completion.
- Squashes in-flight load responses on mispredict.
- Sits between the LSQ and data_memory inside the memory functional unit.

Parameters:
- MEM_LAT, 2, read latency in cycles from mem_en sample to mem_rdata valid; legal range 1..7.
- STARVE_LIMIT, 4, consecutive store grants allowed while a load waits (optional feature only).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- ld_req_valid  in  1  load request pending.
- ld_req_addr  in  32  load byte address.
- ld_req_pd  in  7  destination physical register.
- ld_req_rob  in  5  load ROB tag.
- ld_req_ready  out  1  load accepted this cycle when ld_req_valid is also high.
- st_req_valid  in  1  retired store pending drain.
- st_req_addr  in  32  store address.
- st_req_data  in  32  store data.
- st_req_ready  out  1  store accepted this cycle when st_req_valid is also high.
- rob_head  in  5  current ROB head.
- mispredict  in  1  flush pulse.
- mispredict_tag  in  5  ROB tag of the mispredicted branch.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  write enable, valid with mem_en.
- mem_addr  out  32  memory address.
- mem_wdata  out  32  memory write data.
- mem_rdata  in  32  read data, valid MEM_LAT cycles after mem_en.
- ld_resp_valid  out  1  one-cycle load completion pulse.
- ld_resp_pd  out  7  completing load pd.
- ld_resp_rob  out  5  completing load ROB tag.
- ld_resp_data  out  32  completing load data.
- st_done  out  1  one-cycle store completion pulse.
- busy  out  1  access in flight (state != IDLE).

Behaviour:
- Reset (reset low, asynchronous): state=IDLE. Every output is 0: mem_en, mem_we, mem_addr, mem_wdata, ld_resp_*, st_done, busy, both readys. Latency counter=0, starve counter=0, squash flag=0.
- States: IDLE, LD_WAIT, ST_ACK.
- IDLE:
  - Readys are combinational and asserted only in IDLE, at most one per cycle.
  - Priority: a store wins whenever st_req_valid=1; otherwise a load.
  - A load is not accepted in a cycle where mispredict=1.
  - Store grant: mem_en=1, mem_we=1, mem_addr/mem_wdata driven from the st_req_* inputs in the grant cycle; go to ST_ACK.
  - Load grant: mem_en=1, mem_we=0, mem_addr=ld_req_addr; latch pd/rob; counter=MEM_LAT-1; go to LD_WAIT.
- ST_ACK: st_done=1 for one cycle; return to IDLE. A store costs 2 cycles.
- LD_WAIT:
  - Counter decrements each cycle.
  - When counter reaches 0, capture mem_rdata. In the next cycle ld_resp_valid=1 with the latched pd/rob and the captured data, unless squashed. Return to IDLE in that same cycle.
  - Load-to-response latency is exactly MEM_LAT+1 cycles after the grant cycle.
- Squash:
  - Age is (tag - rob_head) mod 32, computed in 5-bit unsigned arithmetic.
  - If mispredict=1 while in LD_WAIT and age(latched rob) > age(mispredict_tag), set the squash flag.
  - A squashed load completes its memory wait with no early exit; ld_resp_valid stays 0 and the FSM returns to IDLE on schedule.
  - Stores are never squashed (already retired).
- Simultaneous events:
  - mispredict in the response cycle squashes that response.
  - New requests arriving during LD_WAIT/ST_ACK wait; no internal queueing.
- mem_en and mem_we are high only in grant cycles. mem_addr/mem_wdata hold their last values otherwise.
- Reset asserted mid-access abandons the access; no st_done or ld_resp is produced.

Optional Feature:
- Macro DMEM_ARB_STARVE_EN.
- Defined: the starve counter increments on each store grant made while ld_req_valid=1. It clears on a load grant or when ld_req_valid=0. When the counter equals STARVE_LIMIT, the next IDLE grant goes to the load even if st_req_valid=1.
- Undefined: no counter; strict store priority. Loads can starve while stores keep arriving.

Test Plan:
- Reset low mid-LD_WAIT -> all outputs 0 immediately; after release busy=0, no ld_resp_valid pulse.
- Load addr 0x40, pd=12, rob=3, MEM_LAT=2, memory returns 0xDEADBEEF -> ld_resp_valid at grant+3 with pd=12, rob=3, data=0xDEADBEEF.
- Store and load valid in same IDLE cycle -> st_req_ready=1, ld_req_ready=0; st_done next cycle; load granted the cycle after.
- rob_head=30, load rob=2, mispredict_tag=31 during LD_WAIT -> no ld_resp_valid; busy drops on schedule. Repeat with load rob=31, tag=1 (load older) -> response delivered.
- DMEM_ARB_STARVE_EN, STARVE_LIMIT=4, stores continuously valid with a load waiting -> 4 store grants, then the load is granted. Without the macro -> load never granted while stores continue.
